// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage with a 2-entry instruction queue and an IF/ID
//   output register. Issues word-aligned fetch requests to instruction memory,
//   tracks up to two outstanding requests so each in-order response can be
//   tagged with its PC, and drops stale responses after a redirect or a
//   mid-operation reset (DRAIN state).
//
// Ports
//   clk_i          : clock, all state updates on rising edge
//   rst_ni         : synchronous active-low reset
//   pc_enable_i    : 0 = no new fetch request this cycle
//   id_enable_i    : 0 = hold IF/ID outputs
//   id_reset_ni    : 0 = flush IF/ID outputs to a bubble
//   br_sel_i       : taken branch/jump resolved in EX
//   br_target_i    : redirect address (low two bits ignored)
//   imem_req_o     : fetch request valid
//   imem_addr_o    : fetch address (word aligned)
//   imem_ready_i   : memory accepts request when imem_req_o & imem_ready_i
//   imem_rvalid_i  : response valid (in order)
//   imem_rdata_i   : response instruction word
//   ID_pc_o        : PC of instruction in IF/ID
//   ID_inst_o      : instruction in IF/ID
//   ID_valid_o     : 1 = ID_inst_o is a real fetched instruction
//   fetch_empty_o  : 1 = instruction queue empty
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_enable_i,
    input  logic        id_enable_i,
    input  logic        id_reset_ni,
    input  logic        br_sel_i,
    input  logic [31:0] br_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ID_pc_o,
    output logic [31:0] ID_inst_o,
    output logic        ID_valid_o,
    output logic        fetch_empty_o
);

    typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [1:0]  r_out_cnt;
    logic [1:0]  w_out_nxt;
    logic [31:0] r_pend_pc [2];   // [0] = oldest outstanding request address
    logic [1:0]  r_q_cnt;
    logic [31:0] r_q_pc   [2];    // [0] = queue head
    logic [31:0] r_q_inst [2];

    logic        w_space;
    logic        w_accept;
    logic        w_push;
    logic        w_load;
    logic        w_pop;
    logic        w_q_idx;
    logic        w_pend_idx;
    logic        w_unused;

    // Target low bits are discarded by word alignment.
    assign w_unused = ^br_target_i[1:0];

    assign imem_addr_o   = r_pc;
    assign fetch_empty_o = (r_q_cnt == 2'd0);

    // Output / datapath-control combinational process.
    always_comb begin
        // Queue entries plus in-flight requests never exceed the queue depth,
        // so every response always has a slot to land in.
        w_space    = ({1'b0, r_q_cnt} + {1'b0, r_out_cnt}) < 3'd2;
        imem_req_o = rst_ni && (r_state == S_RUN) && pc_enable_i && !br_sel_i && w_space;
        w_accept   = imem_req_o && imem_ready_i;
        w_push     = rst_ni && (r_state == S_RUN) && !br_sel_i && imem_rvalid_i;
        w_load     = rst_ni && id_reset_ni && id_enable_i && !br_sel_i;
        w_pop      = w_load && (r_q_cnt != 2'd0);
        // Write slot for a pushed response, after any same-cycle pop.
        w_q_idx    = r_q_cnt[1] | (r_q_cnt[0] & ~w_pop);
        // Write slot for a newly accepted request address.
        w_pend_idx = imem_rvalid_i ? 1'b0 : r_out_cnt[0];
        w_out_nxt  = r_out_cnt + {1'b0, w_accept} - {1'b0, imem_rvalid_i};
    end

    // Next-state combinational process.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (br_sel_i && (w_out_nxt != 2'd0)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_out_nxt == 2'd0)               w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // State register. Reset keeps counting down requests issued before reset
    // so their late responses are discarded rather than mistaken for new ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= (w_out_nxt != 2'd0) ? S_DRAIN : S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
        r_out_cnt <= w_out_nxt;
    end

    // PC and outstanding-request address tracking.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc <= RESET_PC;
        end else if (br_sel_i) begin
            r_pc <= {br_target_i[31:2], 2'b00};
        end else if (w_accept) begin
            r_pc <= r_pc + 32'd4;
        end

        if (imem_rvalid_i) begin
            r_pend_pc[0] <= r_pend_pc[1];
        end
        if (w_accept) begin
            r_pend_pc[w_pend_idx] <= r_pc;
        end
    end

    // Instruction queue.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || br_sel_i) begin
            r_q_cnt <= 2'd0;
        end else begin
            r_q_cnt <= r_q_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end

        if (w_pop) begin
            r_q_pc[0]   <= r_q_pc[1];
            r_q_inst[0] <= r_q_inst[1];
        end
        if (w_push) begin
            r_q_pc[w_q_idx]   <= r_pend_pc[0];
            r_q_inst[w_q_idx] <= imem_rdata_i;
        end
    end

    // IF/ID register: flush > hold > load.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !id_reset_ni) begin
            ID_pc_o    <= 32'd0;
            ID_inst_o  <= NOP_INST;
            ID_valid_o <= 1'b0;
        end else if (!id_enable_i) begin
            ID_pc_o    <= ID_pc_o;
            ID_inst_o  <= ID_inst_o;
            ID_valid_o <= ID_valid_o;
        end else if (w_pop) begin
            ID_pc_o    <= r_q_pc[0];
            ID_inst_o  <= r_q_inst[0];
            ID_valid_o <= 1'b1;
        end else begin
            ID_pc_o    <= 32'd0;
            ID_inst_o  <= NOP_INST;
            ID_valid_o <= 1'b0;
        end
    end

    // A response into a full queue without a pop would overwrite an entry.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(w_push && (r_q_cnt == 2'd2) && !w_pop));
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        pc_enable_i;
    logic        id_enable_i;
    logic        id_reset_ni;
    logic        br_sel_i;
    logic [31:0] br_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] ID_pc_o;
    logic [31:0] ID_inst_o;
    logic        ID_valid_o;
    logic        fetch_empty_o;

    int n_vec = 0;
    int n_bad = 0;

    // Memory responder state
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] pq_addr [$];
    int          pq_due  [$];
    logic        acc_s;
    logic [31:0] addr_s;

    fetch_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pc_enable_i   (pc_enable_i),
        .id_enable_i   (id_enable_i),
        .id_reset_ni   (id_reset_ni),
        .br_sel_i      (br_sel_i),
        .br_target_i   (br_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ID_pc_o       (ID_pc_o),
        .ID_inst_o     (ID_inst_o),
        .ID_valid_o    (ID_valid_o),
        .fetch_empty_o (fetch_empty_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: sample acceptance at negedge, then after the edge present
    // any response whose latency has elapsed.
    task automatic tick();
        @(negedge clk_i);
        acc_s  = imem_req_o && imem_ready_i;
        addr_s = imem_addr_o;
        @(posedge clk_i);
        #1;
        cyc++;
        if (acc_s) begin
            pq_addr.push_back(addr_s);
            pq_due.push_back(cyc + lat - 1);
        end
        if (pq_addr.size() != 0 && pq_due[0] <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = inst_of(pq_addr[0]);
            void'(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'd0;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; pc_enable_i = 1'b1; id_enable_i = 1'b1; id_reset_ni = 1'b1;
        br_sel_i = 1'b0; br_target_i = 32'd0; imem_ready_i = 1'b1;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;

        // Reset state
        tick(); tick();
        chk1("rst_req",   imem_req_o, 1'b0);
        chk1("rst_valid", ID_valid_o, 1'b0);
        chk ("rst_inst",  ID_inst_o, 32'h0000_0013);
        chk ("rst_pc",    ID_pc_o, 32'd0);
        chk1("rst_empty", fetch_empty_o, 1'b1);

        // Sequential fetch, 1-cycle latency
        rst_ni = 1'b1; #1;
        chk1("c0_req",  imem_req_o, 1'b1);
        chk ("c0_addr", imem_addr_o, 32'h0);
        tick();
        chk ("c1_addr", imem_addr_o, 32'h4);
        tick();
        chk1("c2_req",   imem_req_o, 1'b0);
        chk1("c2_valid", ID_valid_o, 1'b0);
        tick();
        chk1("c3_valid", ID_valid_o, 1'b1);
        chk ("c3_pc",    ID_pc_o, 32'h0);
        chk ("c3_inst",  ID_inst_o, 32'hC0DE_0000);
        chk ("c3_addr",  imem_addr_o, 32'h8);

        // ID stall for three cycles
        id_enable_i = 1'b0;
        tick();
        chk1("st4_req", imem_req_o, 1'b0);
        chk ("st4_pc",  ID_pc_o, 32'h0);
        tick();
        chk1("st5_empty", fetch_empty_o, 1'b0);
        chk1("st5_req",   imem_req_o, 1'b0);
        chk ("st5_pc",    ID_pc_o, 32'h0);
        tick();
        chk1("st6_req", imem_req_o, 1'b0);
        chk ("st6_pc",  ID_pc_o, 32'h0);
        id_enable_i = 1'b1;
        tick();
        chk ("st7_pc",   ID_pc_o, 32'h4);
        chk ("st7_inst", ID_inst_o, 32'hC0DE_0004);
        chk ("st7_addr", imem_addr_o, 32'hC);
        tick();
        chk ("st8_pc", ID_pc_o, 32'h8);
        tick();
        chk1("st9_valid", ID_valid_o, 1'b0);
        tick();
        chk ("st10_pc", ID_pc_o, 32'hC);

        pc_enable_i = 1'b0;
        repeat (6) tick();
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;

        // Redirect with two responses outstanding
        lat = 3; pc_enable_i = 1'b1; #1;
        chk ("br0_addr", imem_addr_o, 32'h0);
        tick();
        chk ("br1_addr", imem_addr_o, 32'h4);
        tick();
        chk1("br2_req", imem_req_o, 1'b0);
        br_sel_i = 1'b1; br_target_i = 32'h0000_0102;
        tick();
        br_sel_i = 1'b0; #1;
        chk1("br3_req",   imem_req_o, 1'b0);
        chk1("br3_valid", ID_valid_o, 1'b0);
        tick();
        chk1("br4_req",   imem_req_o, 1'b0);
        chk1("br4_empty", fetch_empty_o, 1'b1);
        tick();
        chk1("br5_req",   imem_req_o, 1'b1);
        chk ("br5_addr",  imem_addr_o, 32'h100);
        chk1("br5_valid", ID_valid_o, 1'b0);
        tick();
        chk ("br6_addr", imem_addr_o, 32'h104);
        tick(); tick(); tick();
        chk1("br9_valid", ID_valid_o, 1'b0);
        tick();
        chk1("br10_valid", ID_valid_o, 1'b1);
        chk ("br10_pc",    ID_pc_o, 32'h100);
        chk ("br10_inst",  ID_inst_o, 32'hC0DE_0100);

        // Flush has priority over hold; head is kept
        id_reset_ni = 1'b0; id_enable_i = 1'b0;
        tick();
        chk1("fl_valid", ID_valid_o, 1'b0);
        chk ("fl_inst",  ID_inst_o, 32'h0000_0013);
        chk ("fl_pc",    ID_pc_o, 32'h0);
        id_reset_ni = 1'b1; id_enable_i = 1'b1;
        tick();
        chk ("fl_next_pc", ID_pc_o, 32'h104);

        pc_enable_i = 1'b0;
        repeat (8) tick();
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;

        // PC wrap at top of address space
        lat = 1;
        br_sel_i = 1'b1; br_target_i = 32'hFFFF_FFFE;
        tick();
        br_sel_i = 1'b0; #1;
        chk ("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
        pc_enable_i = 1'b1; #1;
        chk1("wr_req", imem_req_o, 1'b1);
        tick();
        chk ("wr_next_addr", imem_addr_o, 32'h0);
        pc_enable_i = 1'b0;
        tick(); tick();
        chk ("wr_id_pc",   ID_pc_o, 32'hFFFF_FFFC);
        chk ("wr_id_inst", ID_inst_o, 32'hC0DE_FFFC);

        // Reset with one request outstanding
        br_sel_i = 1'b1; br_target_i = 32'h0000_0040;
        tick();
        br_sel_i = 1'b0;
        lat = 3; pc_enable_i = 1'b1; #1;
        chk ("mr_addr", imem_addr_o, 32'h40);
        tick();
        rst_ni = 1'b0; #1;
        chk1("mr_rst_req", imem_req_o, 1'b0);
        tick();
        rst_ni = 1'b1; lat = 1; #1;
        chk1("mr_drain_req", imem_req_o, 1'b0);
        tick();
        chk1("mr_drain_req2", imem_req_o, 1'b0);
        tick();
        chk1("mr_run_req",  imem_req_o, 1'b1);
        chk ("mr_run_addr", imem_addr_o, 32'h0);
        chk1("mr_empty",    fetch_empty_o, 1'b1);
        tick(); tick(); tick();
        chk1("mr_valid", ID_valid_o, 1'b1);
        chk ("mr_pc",    ID_pc_o, 32'h0);
        chk ("mr_inst",  ID_inst_o, 32'hC0DE_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
